// File: rtl/rs_simple_if.sv
// rtl/rs_simple_if.sv - dispatch, result-bus and issue signals of the simple-FU reservation station
//
// Groups every non-clock/reset signal of rs_simple.
//   master modport: dispatch/CDB/issue/flush driver (front end + execute stage)
//   slave modport : rs_simple itself
// Ports:
//   flush                      synchronous clear of all slots
//   dispatch_valid/_inst/_rob_num   dispatch request, entry, ROB tag
//   rs_full                    both slots busy
//   cdb_k_valid/_rob_num/_data result bus k broadcast (k = 0, 1)
//   rs_simple_k, rs_simple_k_entry_num  slot k contents and ROB tag
//   selector                   index of the newer slot
//   simple_k_issue             execute stage consumed slot k this cycle

interface rs_simple_if #(
    parameter int INST_W = 114,
    parameter int TAG_W  = 4
);
    logic              flush;
    logic              dispatch_valid;
    logic [INST_W-1:0] dispatch_inst;
    logic [TAG_W-1:0]  dispatch_rob_num;
    logic              rs_full;
    logic              cdb_0_valid;
    logic [TAG_W-1:0]  cdb_0_rob_num;
    logic [31:0]       cdb_0_data;
    logic              cdb_1_valid;
    logic [TAG_W-1:0]  cdb_1_rob_num;
    logic [31:0]       cdb_1_data;
    logic [INST_W-1:0] rs_simple_0;
    logic [INST_W-1:0] rs_simple_1;
    logic [TAG_W-1:0]  rs_simple_0_entry_num;
    logic [TAG_W-1:0]  rs_simple_1_entry_num;
    logic              selector;
    logic              simple_0_issue;
    logic              simple_1_issue;

    modport master (
        output flush, dispatch_valid, dispatch_inst, dispatch_rob_num,
        output cdb_0_valid, cdb_0_rob_num, cdb_0_data,
        output cdb_1_valid, cdb_1_rob_num, cdb_1_data,
        output simple_0_issue, simple_1_issue,
        input  rs_full, rs_simple_0, rs_simple_1,
        input  rs_simple_0_entry_num, rs_simple_1_entry_num, selector
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_inst, dispatch_rob_num,
        input  cdb_0_valid, cdb_0_rob_num, cdb_0_data,
        input  cdb_1_valid, cdb_1_rob_num, cdb_1_data,
        input  simple_0_issue, simple_1_issue,
        output rs_full, rs_simple_0, rs_simple_1,
        output rs_simple_0_entry_num, rs_simple_1_entry_num, selector
    );
endinterface

// File: rtl/rs_simple.sv
// rtl/rs_simple.sv - two-entry reservation station for the simple-FU execute stage
//
// Holds dispatched instructions until both sources are valid, captures
// operands from two result buses (bus 0 has priority), presents both slots
// to the execute stage and frees a slot on its issue strobe.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    rs_simple_if.slave (dispatch, CDBs, issue, flush, slot outputs)
// Entry format:
//   {misc[113:82], aluop[81:76], memwrite[75], memread[74], memtoreg[73],
//    branch[72], regwrite[71], s2[70:39], s2_valid[38], s1[37:6],
//    s1_valid[5], rd[4:0]}
// An invalid source carries its producer ROB tag in the low TAG_W bits.

module rs_simple #(
    parameter int INST_W = 114,
    parameter int TAG_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rs_simple_if.slave   bus
);
    localparam int S1_V = 5;
    localparam int S1_L = 6;
    localparam int S2_V = 38;
    localparam int S2_L = 39;

    logic [1:0]        busy;
    logic [INST_W-1:0] entry_0;
    logic [INST_W-1:0] entry_1;
    logic [TAG_W-1:0]  tag_0;
    logic [TAG_W-1:0]  tag_1;
    logic              sel_q;

    logic [INST_W-1:0] woken_0;
    logic [INST_W-1:0] woken_1;
    logic [INST_W-1:0] woken_d;
    logic              full;
    logic              accept;

    // Capture any pending source whose producer tag is on a result bus.
    // Bus 0 is checked first so it wins when both buses carry the same tag.
    function automatic logic [INST_W-1:0] wake(
        input logic [INST_W-1:0] e,
        input logic              v0,
        input logic [TAG_W-1:0]  t0,
        input logic [31:0]       d0,
        input logic              v1,
        input logic [TAG_W-1:0]  t1,
        input logic [31:0]       d1
    );
        logic [INST_W-1:0] r;
        r = e;
        if (!e[S1_V]) begin
            if (v0 && (t0 == e[S1_L +: TAG_W])) begin
                r[S1_L +: 32] = d0;
                r[S1_V]       = 1'b1;
            end else if (v1 && (t1 == e[S1_L +: TAG_W])) begin
                r[S1_L +: 32] = d1;
                r[S1_V]       = 1'b1;
            end
        end
        if (!e[S2_V]) begin
            if (v0 && (t0 == e[S2_L +: TAG_W])) begin
                r[S2_L +: 32] = d0;
                r[S2_V]       = 1'b1;
            end else if (v1 && (t1 == e[S2_L +: TAG_W])) begin
                r[S2_L +: 32] = d1;
                r[S2_V]       = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        woken_0 = wake(entry_0, bus.cdb_0_valid, bus.cdb_0_rob_num, bus.cdb_0_data,
                       bus.cdb_1_valid, bus.cdb_1_rob_num, bus.cdb_1_data);
        woken_1 = wake(entry_1, bus.cdb_0_valid, bus.cdb_0_rob_num, bus.cdb_0_data,
                       bus.cdb_1_valid, bus.cdb_1_rob_num, bus.cdb_1_data);
        // Same-cycle bypass so a broadcast coinciding with dispatch is not lost.
        woken_d = wake(bus.dispatch_inst, bus.cdb_0_valid, bus.cdb_0_rob_num, bus.cdb_0_data,
                       bus.cdb_1_valid, bus.cdb_1_rob_num, bus.cdb_1_data);
    end

    // Fullness comes from registered state only: a slot freed by issue this
    // cycle cannot be refilled until the next one.
    assign full   = busy[0] & busy[1];
    assign accept = bus.dispatch_valid & ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 2'b00;
            entry_0 <= '0;
            entry_1 <= '0;
            tag_0   <= '0;
            tag_1   <= '0;
            sel_q   <= 1'b0;
        end else if (bus.flush) begin
            busy  <= 2'b00;
            sel_q <= 1'b0;
        end else begin
            if (busy[0]) entry_0 <= woken_0;
            if (busy[1]) entry_1 <= woken_1;
            if (bus.simple_0_issue) busy[0] <= 1'b0;
            if (bus.simple_1_issue) busy[1] <= 1'b0;
            // Dispatch is placed last so it overrides a stray issue of the
            // free slot it is filling.
            if (accept) begin
                if (!busy[0]) begin
                    entry_0 <= woken_d;
                    tag_0   <= bus.dispatch_rob_num;
                    busy[0] <= 1'b1;
                    sel_q   <= 1'b0;
                end else begin
                    entry_1 <= woken_d;
                    tag_1   <= bus.dispatch_rob_num;
                    busy[1] <= 1'b1;
                    sel_q   <= 1'b1;
                end
            end
        end
    end

    // Empty slots must never look ready, so both source-valid bits are gated.
    always_comb begin
        bus.rs_simple_0       = entry_0;
        bus.rs_simple_0[S1_V] = entry_0[S1_V] & busy[0];
        bus.rs_simple_0[S2_V] = entry_0[S2_V] & busy[0];
        bus.rs_simple_1       = entry_1;
        bus.rs_simple_1[S1_V] = entry_1[S1_V] & busy[1];
        bus.rs_simple_1[S2_V] = entry_1[S2_V] & busy[1];
    end

    assign bus.rs_simple_0_entry_num = tag_0;
    assign bus.rs_simple_1_entry_num = tag_1;
    assign bus.rs_full               = full;
    assign bus.selector              = sel_q;
endmodule

// File: tb/tb_rs_simple.sv
// tb/tb_rs_simple.sv - table-driven bench for the two-entry simple-FU reservation station

module tb_rs_simple;
    localparam int INST_W = 114;
    localparam int TAG_W  = 4;
    localparam logic [INST_W-1:0] VMASK = (114'd1 << 38) | (114'd1 << 5);

    logic clk;
    logic rst_n;

    rs_simple_if #(.INST_W(INST_W), .TAG_W(TAG_W)) bus ();

    rs_simple #(.INST_W(INST_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              fl;
        logic              dv;
        logic [INST_W-1:0] inst;
        logic [3:0]        rob;
        logic              c0v;
        logic [3:0]        c0t;
        logic [31:0]       c0d;
        logic              c1v;
        logic [3:0]        c1t;
        logic [31:0]       c1d;
        logic              i0;
        logic              i1;
        logic              chk0;
        logic              chk1;
        logic              e_full;
        logic              e_sel;
        logic [INST_W-1:0] e_o0;
        logic [INST_W-1:0] e_o1;
        logic [3:0]        e_en0;
        logic [3:0]        e_en1;
    } vec_t;

    vec_t vq[$];
    int checks;
    int failures;

    function automatic logic [INST_W-1:0] mk(input logic [5:0] op, input logic [31:0] s2,
                                             input logic s2v, input logic [31:0] s1,
                                             input logic s1v, input logic [4:0] rd);
        return {32'hC0DE_0000 | {26'd0, op}, op, 5'b00001, s2, s2v, s1, s1v, rd};
    endfunction

    function automatic logic [INST_W-1:0] msk(input logic [INST_W-1:0] e);
        return e & ~VMASK;
    endfunction

    function automatic vec_t v(input logic fl, input logic dv, input logic [INST_W-1:0] inst,
                               input logic [3:0] rob,
                               input logic c0v, input logic [3:0] c0t, input logic [31:0] c0d,
                               input logic c1v, input logic [3:0] c1t, input logic [31:0] c1d,
                               input logic i0, input logic i1,
                               input logic chk0, input logic chk1,
                               input logic e_full, input logic e_sel,
                               input logic [INST_W-1:0] e_o0, input logic [INST_W-1:0] e_o1,
                               input logic [3:0] e_en0, input logic [3:0] e_en1);
        vec_t r;
        r.fl = fl; r.dv = dv; r.inst = inst; r.rob = rob;
        r.c0v = c0v; r.c0t = c0t; r.c0d = c0d;
        r.c1v = c1v; r.c1t = c1t; r.c1d = c1d;
        r.i0 = i0; r.i1 = i1; r.chk0 = chk0; r.chk1 = chk1;
        r.e_full = e_full; r.e_sel = e_sel; r.e_o0 = e_o0; r.e_o1 = e_o1;
        r.e_en0 = e_en0; r.e_en1 = e_en1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [INST_W-1:0] act, input logic [INST_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.dispatch_valid = 0; bus.dispatch_inst = '0; bus.dispatch_rob_num = '0;
        bus.cdb_0_valid = 0; bus.cdb_0_rob_num = '0; bus.cdb_0_data = '0;
        bus.cdb_1_valid = 0; bus.cdb_1_rob_num = '0; bus.cdb_1_data = '0;
        bus.simple_0_issue = 0; bus.simple_1_issue = 0;
    endtask

    initial begin
        logic [INST_W-1:0] i1, a, b, c, d, dw, e, ew, f, fw, g, h, p, q, r, s;
        checks = 0;
        failures = 0;

        i1 = mk(6'd1, 32'd7, 1, 32'd5, 1, 5'd3);
        a  = mk(6'd2, 32'h20, 1, 32'h10, 1, 5'd1);
        b  = mk(6'd3, 32'h40, 1, 32'h30, 1, 5'd4);
        c  = mk(6'd4, 32'h60, 1, 32'h50, 1, 5'd7);
        d  = mk(6'd1, 32'h55, 1, 32'd6, 0, 5'd8);
        dw = mk(6'd1, 32'h55, 1, 32'hDEADBEEF, 1, 5'd8);
        e  = mk(6'd4, 32'd9, 0, 32'h77, 1, 5'd2);
        ew = mk(6'd4, 32'h10, 1, 32'h77, 1, 5'd2);
        f  = mk(6'd5, 32'd3, 0, 32'h99, 1, 5'd1);
        fw = mk(6'd5, 32'h11, 1, 32'h99, 1, 5'd1);
        g  = mk(6'd1, 32'd1, 1, 32'd2, 1, 5'd4);
        h  = mk(6'd2, 32'd3, 1, 32'd4, 1, 5'd5);
        p  = mk(6'd2, 32'hA, 1, 32'hB, 1, 5'd5);
        q  = mk(6'd3, 32'hC, 1, 32'hD, 1, 5'd6);
        r  = mk(6'd6, 32'hE, 1, 32'hF, 1, 5'd7);
        s  = mk(6'd7, 32'h1, 1, 32'h2, 1, 5'd9);

        //        fl dv inst rob c0v t0 d0 c1v t1 d1 i0 i1 k0 k1 full sel o0 o1 en0 en1
        vq.push_back(v(0,1,i1,2, 0,0,0, 0,0,0, 0,0, 1,1, 0,0, i1,        '0,        2,0));
        vq.push_back(v(0,0,'0,0, 0,0,0, 0,0,0, 1,0, 1,1, 0,0, msk(i1),   '0,        2,0));
        vq.push_back(v(0,1,a, 1, 0,0,0, 0,0,0, 0,0, 1,1, 0,0, a,         '0,        1,0));
        vq.push_back(v(0,1,b, 4, 0,0,0, 0,0,0, 0,0, 1,1, 1,1, a,         b,         1,4));
        vq.push_back(v(0,1,c, 7, 0,0,0, 0,0,0, 0,0, 1,1, 1,1, a,         b,         1,4));
        vq.push_back(v(0,0,'0,0, 0,0,0, 0,0,0, 1,1, 1,1, 0,1, msk(a),    msk(b),    1,4));
        vq.push_back(v(0,1,d, 5, 0,0,0, 0,0,0, 0,0, 1,1, 0,0, d,         msk(b),    5,4));
        vq.push_back(v(0,0,'0,0, 0,0,0, 1,5,32'h1234, 0,0, 1,1, 0,0, d,  msk(b),    5,4));
        vq.push_back(v(0,0,'0,0, 0,0,0, 1,6,32'hDEADBEEF, 0,0, 1,1, 0,0, dw, msk(b), 5,4));
        vq.push_back(v(0,1,e, 3, 1,9,32'h10, 0,0,0, 0,0, 1,1, 1,1, dw,   ew,        5,3));
        vq.push_back(v(0,0,'0,0, 0,0,0, 0,0,0, 1,1, 1,1, 0,1, msk(dw),   msk(ew),   5,3));
        vq.push_back(v(0,1,f, 6, 0,0,0, 0,0,0, 0,0, 1,1, 0,0, f,         msk(ew),   6,3));
        vq.push_back(v(0,0,'0,0, 1,3,32'h11, 1,3,32'h22, 0,0, 1,1, 0,0, fw, msk(ew), 6,3));
        vq.push_back(v(0,1,g, 8, 0,0,0, 0,0,0, 0,0, 1,1, 1,1, fw,        g,         6,8));
        vq.push_back(v(1,1,h,10, 1,8,32'h5, 0,0,0, 1,0, 0,0, 0,0, '0,    '0,        0,0));
        vq.push_back(v(0,1,p, 1, 0,0,0, 0,0,0, 0,0, 1,0, 0,0, p,         '0,        1,0));
        vq.push_back(v(0,1,q, 2, 0,0,0, 0,0,0, 1,0, 1,1, 0,1, msk(p),    q,         1,2));
        vq.push_back(v(0,1,r, 3, 0,0,0, 0,0,0, 0,0, 1,1, 1,0, r,         q,         3,2));
        vq.push_back(v(0,1,s, 4, 0,0,0, 0,0,0, 0,1, 1,1, 0,0, r,         msk(q),    3,2));

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_full", {113'd0, bus.rs_full}, '0);
        chk("reset_sel", {113'd0, bus.selector}, '0);
        chk("reset_o0", bus.rs_simple_0, '0);
        chk("reset_o1", bus.rs_simple_1, '0);
        chk("reset_en0", {110'd0, bus.rs_simple_0_entry_num}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[k]) begin
            @(negedge clk);
            if (vq[k].dv && bus.rs_full)
                $display("note: vector %0d dispatches into a full station (protocol error, must be ignored)", k);
            bus.flush = vq[k].fl;
            bus.dispatch_valid = vq[k].dv;
            bus.dispatch_inst = vq[k].inst;
            bus.dispatch_rob_num = vq[k].rob;
            bus.cdb_0_valid = vq[k].c0v; bus.cdb_0_rob_num = vq[k].c0t; bus.cdb_0_data = vq[k].c0d;
            bus.cdb_1_valid = vq[k].c1v; bus.cdb_1_rob_num = vq[k].c1t; bus.cdb_1_data = vq[k].c1d;
            bus.simple_0_issue = vq[k].i0;
            bus.simple_1_issue = vq[k].i1;
            @(posedge clk);
            #1;
            idle_inputs();
            chk($sformatf("v%0d_full", k), {113'd0, bus.rs_full}, {113'd0, vq[k].e_full});
            chk($sformatf("v%0d_sel", k), {113'd0, bus.selector}, {113'd0, vq[k].e_sel});
            if (vq[k].chk0) begin
                chk($sformatf("v%0d_o0", k), bus.rs_simple_0, vq[k].e_o0);
                chk($sformatf("v%0d_en0", k), {110'd0, bus.rs_simple_0_entry_num}, {110'd0, vq[k].e_en0});
            end else begin
                chk($sformatf("v%0d_o0_valid", k), bus.rs_simple_0 & VMASK, '0);
            end
            if (vq[k].chk1) begin
                chk($sformatf("v%0d_o1", k), bus.rs_simple_1, vq[k].e_o1);
                chk($sformatf("v%0d_en1", k), {110'd0, bus.rs_simple_1_entry_num}, {110'd0, vq[k].e_en1});
            end else begin
                chk($sformatf("v%0d_o1_valid", k), bus.rs_simple_1 & VMASK, '0);
            end
        end

        // Asynchronous reset mid-cycle: slot 0 holds r, clear must not wait for an edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_o0", bus.rs_simple_0, '0);
        chk("async_en0", {110'd0, bus.rs_simple_0_entry_num}, '0);
        chk("async_o1", bus.rs_simple_1, '0);
        chk("async_full", {113'd0, bus.rs_full}, '0);
        chk("async_sel", {113'd0, bus.selector}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
